// File: rtl/sipo_shift_reg.sv
// Serial-in, parallel-out word assembler: collects WIDTH qualified bits MSB first
// and presents each completed word with a one-cycle valid strobe. Option macro: SIPO_PARITY_EN.
module sipo_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             busy
`ifdef SIPO_PARITY_EN
    ,
    output logic             parity_err
`endif
);

`ifdef SIPO_PARITY_EN
    localparam int N = WIDTH + 1;
`else
    localparam int N = WIDTH;
`endif
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic [WIDTH-1:0] sr_reg;
    logic [WIDTH-1:0] sr_shift;
    logic [WIDTH-1:0] word_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] q_reg;
    logic             valid_reg;
    logic             last_bit;

    assign sr_shift = {sr_reg[WIDTH-2:0], d};
    assign last_bit = (cnt_reg == CNT_LAST);

`ifdef SIPO_PARITY_EN
    // The final qualified bit is parity only, so the word is already complete in sr.
    assign word_next = sr_reg;
`else
    assign word_next = sr_shift;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_reg    <= '0;
            cnt_reg   <= '0;
            q_reg     <= '0;
            valid_reg <= 1'b0;
        end else if (clr) begin
            sr_reg    <= '0;
            cnt_reg   <= '0;
            valid_reg <= 1'b0;
        end else if (en) begin
            if (last_bit) begin
                q_reg     <= word_next;
                sr_reg    <= '0;
                cnt_reg   <= '0;
                valid_reg <= 1'b1;
            end else begin
                sr_reg    <= sr_shift;
                cnt_reg   <= cnt_reg + CW'(1);
                valid_reg <= 1'b0;
            end
        end else begin
            valid_reg <= 1'b0;
        end
    end

`ifdef SIPO_PARITY_EN
    logic parity_err_reg;

    // Even parity: the word plus its parity bit must XOR to zero; clr leaves the flag alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err_reg <= 1'b0;
        end else if (!clr && en && last_bit) begin
            parity_err_reg <= ^{sr_reg, d};
        end
    end

    assign parity_err = parity_err_reg;
`endif

    assign q     = q_reg;
    assign valid = valid_reg;
    assign busy  = (cnt_reg != '0);

endmodule

// File: tb/tb_sipo_shift_reg.sv
// Scoreboard bench for sipo_shift_reg: stimulus queues expected words, a monitor
// pops and compares on every valid strobe. Exercises SIPO_PARITY_EN when defined.
module tb_sipo_shift_reg;
    localparam int WIDTH = 8;
`ifdef SIPO_PARITY_EN
    localparam int N = WIDTH + 1;
`else
    localparam int N = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             d   = 1'b0;
    logic             en  = 1'b0;
    logic             clr = 1'b0;
    logic [WIDTH-1:0] q;
    logic             valid;
    logic             busy;
    logic             parity_err;

    sipo_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .d          (d),
        .en         (en),
        .clr        (clr),
        .q          (q),
        .valid      (valid),
        .busy       (busy)
`ifdef SIPO_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

`ifndef SIPO_PARITY_EN
    assign parity_err = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] word;
        logic             perr;
    } exp_t;

    exp_t sb[$];
    int   vcyc[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_pushed = 0;
    int   n_valid = 0;
    int   cyc = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every valid strobe must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                n_valid++;
                vcyc.push_back(cyc);
                chk("valid_not_consecutive", {31'd0, prev_valid}, 32'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("word_q", {24'd0, q}, {24'd0, e.word});
`ifdef SIPO_PARITY_EN
                    chk("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
`endif
                    $display("word %02h valid at cycle %0d perr=%0b", q, cyc, parity_err);
                end
            end
            prev_valid = (valid === 1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_bit(input logic b, input int gap);
        @(negedge clk);
        en  = 1'b1;
        d   = b;
        clr = 1'b0;
        repeat (gap) begin
            @(negedge clk);
            en = 1'b0;
        end
    endtask

    // Expectation is queued before the bits go out so gapped words cannot race the monitor.
    task automatic send_word(input logic [WIDTH-1:0] w, input int gap, input logic pbit);
        exp_t e;
        e.word = w;
        e.perr = ^{w, pbit};
        sb.push_back(e);
        n_pushed++;
        for (int i = WIDTH - 1; i >= 0; i--) send_bit(w[i], gap);
`ifdef SIPO_PARITY_EN
        send_bit(pbit, gap);
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            en  = 1'b0;
            clr = 1'b0;
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        clr = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] pat;
        int               c0;
        int               c1;

        do_reset(2);
        chk("reset_q", {24'd0, q}, 32'd0);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);

        // Continuous en: 1,0,1,0,0,1,0,1
        send_word(8'hA5, 0, 1'b0);
        idle(3);
        chk("a5_q_after", {24'd0, q}, 32'hA5);
        chk("a5_busy_after", {31'd0, busy}, 32'd0);

        // Gapped en: q must hold A5 until the 3C word completes
        pat = 8'h3C;
        sb.push_back('{word: pat, perr: 1'b0});
        n_pushed++;
        for (int i = WIDTH - 1; i >= 4; i--) send_bit(pat[i], 3);
        chk("gap_q_hold", {24'd0, q}, 32'hA5);
        chk("gap_busy_mid", {31'd0, busy}, 32'd1);
        for (int i = 3; i >= 0; i--) send_bit(pat[i], 3);
`ifdef SIPO_PARITY_EN
        send_bit(1'b0, 3);
`endif
        idle(2);
        chk("gap_q", {24'd0, q}, 32'h3C);

        // Abort: 4 bits, then clr with en=1, then a full FF word
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        @(negedge clk);
        clr = 1'b1;
        en  = 1'b1;
        d   = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        en  = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_q_hold", {24'd0, q}, 32'h3C);
        chk("abort_no_valid", {31'd0, valid}, 32'd0);
        send_word(8'hFF, 0, 1'b0);
        idle(2);
        chk("ff_q", {24'd0, q}, 32'hFF);

        // Mid-word reset after 5 bits discards the word and clears q
        for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
        do_reset(1);
        chk("midrst_q", {24'd0, q}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        send_word(8'h5A, 0, 1'b0);
        idle(2);
        chk("restart_q", {24'd0, q}, 32'h5A);

        // Back-to-back words: valid every N cycles
        vcyc.delete();
        send_word(8'h01, 0, 1'b0);
        send_word(8'h80, 0, 1'b0);
        idle(3);
        chk("b2b_valid_count", vcyc.size(), 32'd2);
        if (vcyc.size() == 2) begin
            c0 = vcyc[0];
            c1 = vcyc[1];
            chk("b2b_spacing", c1 - c0, N);
        end
        chk("b2b_q", {24'd0, q}, 32'h80);

`ifdef SIPO_PARITY_EN
        send_word(8'hA5, 0, 1'b0);
        idle(2);
        chk("par_ok_err", {31'd0, parity_err}, 32'd0);
        send_word(8'hA5, 0, 1'b1);
        idle(2);
        chk("par_bad_err", {31'd0, parity_err}, 32'd1);
        chk("par_bad_q", {24'd0, q}, 32'hA5);
        // clr must not touch parity_err
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("par_clr_hold", {31'd0, parity_err}, 32'd1);
        do_reset(2);
        chk("par_rst_clear", {31'd0, parity_err}, 32'd0);
`endif

        // Reset after traffic
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        do_reset(2);
        chk("final_reset_q", {24'd0, q}, 32'd0);
        chk("final_reset_valid", {31'd0, valid}, 32'd0);
        chk("final_reset_busy", {31'd0, busy}, 32'd0);

        idle(2);
        chk("scoreboard_empty", sb.size(), 32'd0);
        chk("valid_total", n_valid, n_pushed);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
